ntr_cmd_capture: RTL and testbench
==================================

Name: ntr_cmd_capture

Overview:
- Captures the 8-byte NTR (cartridge bus) command that a host drives over an 8-bit parallel bus.
- The raw ntr_clk and ntr_cs1 inputs are debounced in the fabric clock domain. A byte is sampled on each debounced ntr_clk rising edge while the card is selected (debounced cs1 low).
- Bytes are assembled into a 64-bit command word. `ready` flags a complete command.
- Sits between the cartridge pins and the command-decoding FSM in the top level.

Parameters:
- DATA_W, 8, width of ntr_data (one byte per ntr_clk edge).
- DB_STABLE, 2, consecutive clk cycles a synchronized input must differ from the debounced output before the output follows it.
- CLK_INIT, 0, reset value of debounced ntr_clk.
- CS_INIT, 1, reset value of debounced ntr_cs1 (deselected).

Ports:
- clk, input, 1, fabric clock; all state in this clock domain.
- rst, input, 1, asynchronous active-high reset.
- ntr_clk, input, 1, raw NTR bus clock (asynchronous, may bounce).
- ntr_cs1, input, 1, raw NTR chip select, active low.
- ntr_data, input, DATA_W, raw NTR data byte.
- command, output, 64, assembled command; first byte received in [63:56], last in [7:0].
- ready, output, 1, high when 8 bytes have been captured in the current selection.
- count, output, 4, number of bytes captured in the current selection, 0..8.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: command=0, ready=0, count=0. Debounced clk=CLK_INIT, debounced cs=CS_INIT. Edge-detect history = CLK_INIT. Debounce counters = 0.
- Debouncer, per signal:
  - in_q samples the raw input every clk.
  - Counter clears whenever in_q == out.
  - Counter increments while in_q != out.
  - When the counter reaches DB_STABLE-1 and in_q still differs, out <= in_q and the counter clears.
  - Clean-edge latency, raw change to output change, is DB_STABLE+1 clk edges (3 with defaults).
  - A glitch shorter than DB_STABLE cycles produces no output change.
- Data path: ntr_data is registered once into data_q every clk. The host must hold data stable for at least DB_STABLE+3 clk cycles after the ntr_clk rising edge.
- Edge detect: rise = db_clk & ~db_clk_d, where db_clk_d is db_clk delayed by one clk.
- Capture, one clk after rise, when db_cs==0 and count<8:
  - command <= {command[55:0], data_q}.
  - count <= count+1.
  - ready <= 1 when the new count equals 8.
- Overflow: rising edges when count==8 are ignored. command and count hold; ready stays 1.
- Rising edges while db_cs==1 are ignored.
- Deselect (db_cs==1, level): count <= 0 and ready <= 0. command keeps its last value.
- Simultaneous deselect and rise in the same cycle: deselect wins; no byte is captured.
- Reset mid-frame: all state clears immediately. The next frame starts at count 0 with the first byte into the low position of the shifter.
- count saturates at 8; it never wraps.

Optional Feature:
- Macro: NTR_OVERRUN_EN.
- Defined: adds output `overrun` (1 bit, reset 0).
  - Set on the first qualifying rising edge while count==8 and db_cs==0.
  - Sticky until deselect or reset.
  - command is unaffected.
- Undefined: the port and its logic are absent; excess bytes are silently dropped.

Decomposition:
- Package ntr_pkg holds:
  - CMD_BYTES=8, CMD_W=64.
  - COUNT_W=4.
  - Typedef cmd_t (logic [63:0]).
- One sub-module, ntr_debounce (params INIT, STABLE; ports clk, rst, din, dout), instantiated twice: for ntr_clk and ntr_cs1.
- Edge detect, shifter and counters live in ntr_cmd_capture.

Test Plan:
- Reset, then idle: command=0, ready=0, count=0. Debounced cs high, so no capture on ntr_clk toggles.
- Frame with cs1 low, 8 clean ntr_clk pulses (each high/low 10 clk), bytes 01,02,..,07,FF:
  - count steps 1..8.
  - ready rises on the 8th byte.
  - command=0x01020304050607FF, so command[7:0]=FF and command[56]=1.
- 1-cycle glitch pulses on ntr_clk while selected: no capture, count unchanged. A 3-cycle pulse is captured (DB_STABLE=2).
- Raise cs1 after a full frame: ready->0 and count->0 within DB_STABLE+2 clk; command holds 0x01020304050607FF.
- Send 10 bytes in one selection: count stays 8 and command equals the first 8 bytes. With NTR_OVERRUN_EN, overrun=1 after the 9th byte and clears on deselect.
- Assert rst after 3 bytes, release, then send a full frame: outputs clear asynchronously, and the new frame assembles correctly from count 0.

Source files
------------

// File: rtl/ntr_pkg.sv
// Shared constants and types for the NTR command capture block.
package ntr_pkg;
    localparam int CMD_BYTES = 8;
    localparam int CMD_W     = 64;
    localparam int COUNT_W   = 4;

    typedef logic [CMD_W-1:0] cmd_t;
endpackage

// File: rtl/ntr_debounce.sv
// Synchronizing debouncer: the output follows the sampled input only after it
// has differed from the output for STABLE consecutive clk cycles.
module ntr_debounce #(
    parameter logic INIT   = 1'b0,
    parameter int   STABLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CNT_W = (STABLE > 1) ? $clog2(STABLE) : 1;

    logic             in_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= INIT;
            dout <= INIT;
            cnt  <= '0;
        end else begin
            in_q <= din;
            if (in_q == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(STABLE - 1)) begin
                dout <= in_q;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ntr_cmd_capture.sv
// Debounces the NTR bus clock/select and assembles the 8-byte command word.
// Optional sticky overrun flag when NTR_OVERRUN_EN is defined.
module ntr_cmd_capture
    import ntr_pkg::*;
#(
    parameter int   DATA_W    = 8,
    parameter int   DB_STABLE = 2,
    parameter logic CLK_INIT  = 1'b0,
    parameter logic CS_INIT   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ntr_clk,
    input  logic               ntr_cs1,
    input  logic [DATA_W-1:0]  ntr_data,
    output cmd_t               command,
    output logic               ready,
`ifdef NTR_OVERRUN_EN
    output logic               overrun,
`endif
    output logic [COUNT_W-1:0] count
);
    logic              db_clk;
    logic              db_cs;
    logic              db_clk_d;
    logic              rise;
    logic [DATA_W-1:0] data_q;
    logic              full;

    ntr_debounce #(.INIT(CLK_INIT), .STABLE(DB_STABLE)) u_db_clk (
        .clk  (clk),
        .rst  (rst),
        .din  (ntr_clk),
        .dout (db_clk)
    );

    ntr_debounce #(.INIT(CS_INIT), .STABLE(DB_STABLE)) u_db_cs (
        .clk  (clk),
        .rst  (rst),
        .din  (ntr_cs1),
        .dout (db_cs)
    );

    // Data is only registered; the host holds it long enough to cover debounce latency.
    always_ff @(posedge clk) begin
        data_q <= ntr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_clk_d <= CLK_INIT;
        end else begin
            db_clk_d <= db_clk;
        end
    end

    assign rise = db_clk & ~db_clk_d;
    assign full = (count == COUNT_W'(CMD_BYTES));

    // Deselect has priority over a coincident rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            command <= '0;
            count   <= '0;
            ready   <= 1'b0;
        end else if (db_cs) begin
            count <= '0;
            ready <= 1'b0;
        end else if (rise && !full) begin
            command <= {command[CMD_W-DATA_W-1:0], data_q};
            count   <= count + 1'b1;
            ready   <= (count == COUNT_W'(CMD_BYTES - 1));
        end
    end

`ifdef NTR_OVERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (db_cs) begin
            overrun <= 1'b0;
        end else if (rise && full) begin
            overrun <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ntr_cmd_capture.sv
// Directed + randomized bench for ntr_cmd_capture with a byte-level reference model.
// Define NTR_OVERRUN_EN to also check the overrun flag.
module tb_ntr_cmd_capture;
    import ntr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ntr_clk = 1'b0;
    logic        ntr_cs1 = 1'b1;
    logic [7:0]  ntr_data = 8'h00;
    cmd_t        command;
    logic        ready;
    logic [3:0]  count;
`ifdef NTR_OVERRUN_EN
    logic        overrun;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state (byte granularity)
    logic [63:0] m_cmd = 64'h0;
    int          m_cnt = 0;
    bit          m_sel = 0;
    bit          m_ovr = 0;

    ntr_cmd_capture dut (
        .clk      (clk),
        .rst      (rst),
        .ntr_clk  (ntr_clk),
        .ntr_cs1  (ntr_cs1),
        .ntr_data (ntr_data),
        .command  (command),
        .ready    (ready),
`ifdef NTR_OVERRUN_EN
        .overrun  (overrun),
`endif
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"}, 64'(count), 64'(m_cnt));
        check({tag, ".ready"}, 64'(ready), 64'(m_cnt == 8));
        check({tag, ".command"}, command, m_cmd);
`ifdef NTR_OVERRUN_EN
        check({tag, ".overrun"}, 64'(overrun), 64'(m_ovr));
`endif
    endtask

    // One ntr_clk pulse carrying a byte; data held for the whole pulse.
    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        ntr_data = b;
        ntr_clk  = 1'b1;
        tick(hi);
        ntr_clk  = 1'b0;
        tick(lo);
        if (m_sel && hi >= 2) begin
            if (m_cnt < 8) begin
                m_cmd = (m_cmd << 8) | 64'(b);
                m_cnt++;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    task automatic select_card();
        ntr_cs1 = 1'b0;
        tick(6);
        m_sel = 1;
    endtask

    task automatic deselect_card();
        ntr_cs1 = 1'b1;
        tick(4);
        m_sel = 0;
        m_cnt = 0;
        m_ovr = 0;
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++)
            send_byte(8'($urandom), $urandom_range(6, 12), $urandom_range(6, 12));
    endtask

    initial begin
        // Reset and idle
        rst = 1'b1;
        tick(3);
        check_model("reset");
        rst = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) send_byte(8'hA5, 10, 10);
        check_model("idle_deselected");

        // Known frame 01..07,FF
        select_card();
        for (int i = 1; i <= 8; i++) begin
            send_byte((i == 8) ? 8'hFF : 8'(i), 10, 10);
            check_model($sformatf("frame_byte%0d", i));
        end
        check("frame_cmd_const", command, 64'h01020304050607FF);
        check("frame_bit56", 64'(command[56]), 64'h1);

        // Deselect clears count/ready within DB_STABLE+2 clk, command holds
        deselect_card();
        check_model("deselect");
        check("deselect_cmd_const", command, 64'h01020304050607FF);

        // Glitches ignored, 3-cycle pulse captured
        select_card();
        send_random(2);
        check_model("pre_glitch");
        for (int i = 0; i < 3; i++) send_byte(8'h5A, 1, 8);
        check_model("glitch");
        send_byte(8'hC3, 3, 8);
        check_model("short_pulse");

        // Overflow: total 10 bytes in this selection
        send_random(5);
        check_model("full");
        send_byte(8'h99, 10, 10);
        check_model("overflow9");
        send_byte(8'h77, 10, 10);
        check_model("overflow10");
        deselect_card();
        check_model("overflow_deselect");

        // Reset mid-frame
        select_card();
        send_random(3);
        check_model("pre_reset");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        m_cmd = 64'h0; m_cnt = 0; m_ovr = 0; m_sel = 0;
        check_model("async_reset");
        tick(2);
        rst = 1'b0;
        tick(6);
        m_sel = 1;
        send_random(8);
        check_model("post_reset_frame");

        // Random frames of random length
        for (int f = 0; f < 6; f++) begin
            deselect_card();
            check_model($sformatf("rand_desel%0d", f));
            select_card();
            send_random($urandom_range(0, 10));
            check_model($sformatf("rand_frame%0d", f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
